// File: rtl/msm_pkg.sv
// -----------------------------------------------------------------------------
// msm_pkg
// Shared definitions for the MSM bucket pipeline.
//   SINGLE_POINT_WIDTH : width of one coordinate (30 bits)
//   POINT_WIDTH        : one point = 3 coordinates
//   INDEX_WIDTH        : bucket index width
//   NULL_BUCKET        : bucket index that does not exist (entries are dropped)
//   entry_t            : one FIFO entry, laid out as {index, pair} with the
//                        index in the most significant bits
// -----------------------------------------------------------------------------
package msm_pkg;

  localparam int SINGLE_POINT_WIDTH = 30;
  localparam int POINT_WIDTH        = 3 * SINGLE_POINT_WIDTH;
  localparam int INDEX_WIDTH        = 4;
  localparam int NULL_BUCKET        = 0;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0]   index;
    logic [2*POINT_WIDTH-1:0] pair;
  } entry_t;

endpackage

// File: rtl/dispatch_skid_buf.sv
// -----------------------------------------------------------------------------
// dispatch_skid_buf
// Two-entry in-order holding buffer. Slot 0 is always the head. A push and a
// pop in the same cycle keep the count unchanged. A push into a full buffer
// with no pop is ignored so the buffer can never overflow. Popped slots are
// refilled with zero, so the head reads as zero whenever the buffer is empty.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_data behind the current contents
//   i_data      : entry to write
//   i_pop       : remove the head (ignored when empty)
//   o_valid     : head holds an entry
//   o_data      : head entry
//   o_count     : number of stored entries (0..2)
// -----------------------------------------------------------------------------
module dispatch_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_slot0;
  logic [W-1:0] r_slot1;
  logic [1:0]   r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A full buffer only accepts a new entry when the head leaves this cycle.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b01: begin
          r_slot0 <= r_slot1;
          r_slot1 <= '0;
          r_count <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) r_slot0 <= i_data;
          else                 r_slot1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_slot0 <= i_data;
          end else begin
            r_slot0 <= r_slot1;
            r_slot1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_slot0;
  assign o_count = r_count;

endmodule

// File: rtl/fifo_dispatcher.sv
// -----------------------------------------------------------------------------
// fifo_dispatcher
// Pulls point pairs from a FIFO into a 2-entry holding buffer and offers them
// in order to the point adder. Entries for the null bucket are dropped on
// capture. With FIFO_DISPATCHER_HAZARD_CHECK_EN defined, a bitmap tracks
// buckets whose addition is still inside the adder, and a head whose bucket
// is in flight stalls (blocking younger entries) until that bucket retires.
// Without the macro the head dispatches regardless of bucket and retire_* is
// ignored.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   fifo_empty / fifo_re  : FIFO status and read enable
//   fifo_pout, fifo_index : FIFO data, valid the cycle after an accepted read
//   add_valid / add_ready : offer to the adder (valid/ready handshake)
//   add_p, add_index      : offered pair and bucket
//   retire_valid/_index   : adder finished an addition for that bucket
//   busy                  : buffered, pending or in-flight work exists
//
// Handshake: a transfer happens on every cycle with add_valid && add_ready.
// Once add_valid is high it stays high, with add_p/add_index unchanged, until
// the transfer happens; add_valid never depends on add_ready.
// -----------------------------------------------------------------------------
module fifo_dispatcher
  import msm_pkg::*;
#(
  parameter int DATA_WIDTH  = msm_pkg::POINT_WIDTH,
  parameter int INDEX_WIDTH = msm_pkg::INDEX_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  output logic                    fifo_re,
  input  logic [2*DATA_WIDTH-1:0] fifo_pout,
  input  logic [INDEX_WIDTH-1:0]  fifo_index,
  output logic                    add_valid,
  input  logic                    add_ready,
  output logic [2*DATA_WIDTH-1:0] add_p,
  output logic [INDEX_WIDTH-1:0]  add_index,
  input  logic                    retire_valid,
  input  logic [INDEX_WIDTH-1:0]  retire_index,
  output logic                    busy
);

  // Buffer entries use the entry_t layout {index, pair}.
  localparam int ENTRY_W = INDEX_WIDTH + 2 * DATA_WIDTH;

  logic                    r_rd_pend;
  logic                    w_cap_push;
  logic [ENTRY_W-1:0]      w_cap_data;
  logic                    w_head_valid;
  logic [ENTRY_W-1:0]      w_head;
  logic [1:0]              w_occ;
  logic [1:0]              w_load;
  logic                    w_dispatch;
  logic                    w_head_clear;
  logic                    w_inflight_any;
  logic [INDEX_WIDTH-1:0]  w_head_index;

  // FIFO data arrives one cycle after the read, so one pending read at most.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_pend <= 1'b0;
    else        r_rd_pend <= fifo_re;
  end

  assign w_cap_push = r_rd_pend && (fifo_index != INDEX_WIDTH'(NULL_BUCKET));
  assign w_cap_data = {fifo_index, fifo_pout};

  dispatch_skid_buf #(
    .W (ENTRY_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_cap_push),
    .i_data  (w_cap_data),
    .i_pop   (w_dispatch),
    .o_valid (w_head_valid),
    .o_data  (w_head),
    .o_count (w_occ)
  );

  assign w_head_index = w_head[ENTRY_W-1 -: INDEX_WIDTH];

  // The slot freed by a dispatch this cycle counts as free, which keeps the
  // pipe streaming at one entry per cycle; the capture that follows a read
  // still always finds room.
  assign w_load  = w_occ - {1'b0, w_dispatch} + {1'b0, r_rd_pend};
  assign fifo_re = rst_n && !fifo_empty && (w_load < 2'd2);

  assign add_valid  = w_head_valid && w_head_clear;
  assign add_p      = w_head[2*DATA_WIDTH-1:0];
  assign add_index  = w_head_index;
  assign w_dispatch = add_valid && add_ready;

`ifdef FIFO_DISPATCHER_HAZARD_CHECK_EN
  localparam int NUM_BUCKETS = 2 ** INDEX_WIDTH;

  logic [NUM_BUCKETS-1:0] r_inflight;
  logic [NUM_BUCKETS-1:0] w_inflight_nxt;

  // A dispatched bucket is never already in flight, so the retire clear and
  // the dispatch set can never collide on the same bit.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (retire_valid) w_inflight_nxt[retire_index] = 1'b0;
    if (w_dispatch)   w_inflight_nxt[add_index]    = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight <= '0;
    else        r_inflight <= w_inflight_nxt;
  end

  assign w_head_clear   = !r_inflight[w_head_index];
  assign w_inflight_any = |r_inflight;
`else
  logic w_unused_retire;

  assign w_unused_retire = ^{retire_valid, retire_index};
  assign w_head_clear    = 1'b1;
  assign w_inflight_any  = 1'b0;
`endif

  assign busy = (w_occ != 2'd0) || r_rd_pend || w_inflight_any;

endmodule

// File: tb/tb_fifo_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_fifo_dispatcher
// Directed bench for fifo_dispatcher. A small FIFO model feeds the DUT; every
// step drives inputs on the falling edge and checks outputs 1 ns later against
// hand-derived values. Expectations that depend on
// FIFO_DISPATCHER_HAZARD_CHECK_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_fifo_dispatcher;
  import msm_pkg::*;

  localparam int DW = POINT_WIDTH;
  localparam int IW = INDEX_WIDTH;
  localparam int PW = 2 * DW;

`ifdef FIFO_DISPATCHER_HAZARD_CHECK_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_re;
  logic [PW-1:0] fifo_pout;
  logic [IW-1:0] fifo_index;
  logic          add_valid;
  logic          add_ready;
  logic [PW-1:0] add_p;
  logic [IW-1:0] add_index;
  logic          retire_valid;
  logic [IW-1:0] retire_index;
  logic          busy;

  int checks = 0;
  int errors = 0;

  fifo_dispatcher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_re      (fifo_re),
    .fifo_pout    (fifo_pout),
    .fifo_index   (fifo_index),
    .add_valid    (add_valid),
    .add_ready    (add_ready),
    .add_p        (add_p),
    .add_index    (add_index),
    .retire_valid (retire_valid),
    .retire_index (retire_index),
    .busy         (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  entry_t     mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  initial begin
    fifo_pout  = '0;
    fifo_index = '0;
  end

  always @(posedge clk) begin
    if (fifo_re && !fifo_empty) begin
      fifo_pout  <= mem[rd_ptr].pair;
      fifo_index <= mem[rd_ptr].index;
      rd_ptr     <= rd_ptr + 8'd1;
    end
  end

  // Dispatch counter, used to check that no entry is lost or duplicated.
  int disp_n = 0;
  always @(posedge clk) begin
    if (rst_n && add_valid && add_ready) disp_n <= disp_n + 1;
  end

  // ---------------- helpers ----------------
  function automatic logic [PW-1:0] mk_p(input logic [7:0] k);
    mk_p = {20{1'b1, k}};
  endfunction

  task automatic push(input int idx);
    mem[wr_ptr].index = IW'(idx);
    mem[wr_ptr].pair  = mk_p(wr_ptr);
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] base;
  int         d0;

  // ---------------- directed sequence ----------------
  initial begin
    rst_n        = 1'b0;
    add_ready    = 1'b0;
    retire_valid = 1'b0;
    retire_index = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_fifo_re",   fifo_re,   0);
    check("rst_add_valid", add_valid, 0);
    check("rst_add_index", add_index, 0);
    check("rst_add_p",     add_p,     0);
    check("rst_busy",      busy,      0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- S1: indices 1,2,3, immediate retires ----
    @(negedge clk);
    base = wr_ptr; push(1); push(2); push(3); add_ready = 1'b1;
    #1;
    check("s1_re_c0",    fifo_re,   1);
    check("s1_valid_c0", add_valid, 0);
    @(negedge clk); #1;
    check("s1_re_c1",    fifo_re,   1);
    check("s1_valid_c1", add_valid, 0);
    @(negedge clk); #1;
    check("s1_valid_c2", add_valid, 1);
    check("s1_index_c2", add_index, 1);
    check("s1_p_c2",     add_p,     mk_p(base));
    check("s1_re_c2",    fifo_re,   1);
    @(negedge clk); retire_valid = 1'b1; retire_index = 4'd1; #1;
    check("s1_valid_c3", add_valid, 1);
    check("s1_index_c3", add_index, 2);
    check("s1_re_c3",    fifo_re,   0);
    @(negedge clk); retire_index = 4'd2; #1;
    check("s1_valid_c4", add_valid, 1);
    check("s1_index_c4", add_index, 3);
    check("s1_p_c4",     add_p,     mk_p(base + 8'd2));
    @(negedge clk); retire_index = 4'd3; #1;
    check("s1_valid_c5", add_valid, 0);
    check("s1_busy_c5",  busy,      HZ);
    @(negedge clk); retire_valid = 1'b0; #1;
    check("s1_busy_end", busy, 0);

    // ---- S2: indices 5,5, retire releases the second ----
    @(negedge clk);
    base = wr_ptr; push(5); push(5); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("s2_valid_c2", add_valid, 1);
    check("s2_index_c2", add_index, 5);
    @(negedge clk); #1;
    check("s2_valid_c3", add_valid, !HZ);
    check("s2_index_c3", add_index, 5);
    check("s2_p_c3",     add_p,     mk_p(base + 8'd1));
    check("s2_busy_c3",  busy,      1);
    @(negedge clk); retire_valid = 1'b1; retire_index = 4'd5; #1;
    check("s2_valid_c4", add_valid, 0);
    @(negedge clk); retire_valid = 1'b0; #1;
    check("s2_valid_c5", add_valid, HZ);
    @(negedge clk); retire_valid = 1'b1; #1;
    check("s2_valid_c6", add_valid, 0);
    @(negedge clk); retire_valid = 1'b0; #1;
    check("s2_busy_end", busy, 0);

    // ---- S3: indices 3,0,4, bucket 0 is dropped ----
    @(negedge clk);
    base = wr_ptr; d0 = disp_n; push(3); push(0); push(4); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("s3_valid_c2", add_valid, 1);
    check("s3_index_c2", add_index, 3);
    @(negedge clk); retire_valid = 1'b1; retire_index = 4'd3; #1;
    check("s3_valid_c3", add_valid, 0);
    check("s3_busy_c3",  busy,      1);
    @(negedge clk); retire_valid = 1'b0; #1;
    check("s3_valid_c4", add_valid, 1);
    check("s3_index_c4", add_index, 4);
    check("s3_p_c4",     add_p,     mk_p(base + 8'd2));
    @(negedge clk); retire_valid = 1'b1; retire_index = 4'd4; #1;
    check("s3_valid_c5", add_valid, 0);
    check("s3_busy_c5",  busy,      HZ);
    @(negedge clk); retire_valid = 1'b0; #1;
    check("s3_busy_end", busy, 0);
    check("s3_count",    PW'(disp_n - d0), 2);

    // ---- S4: adder stalled 10 cycles with 6 entries queued ----
    @(negedge clk);
    base = wr_ptr; d0 = disp_n; add_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(6 + i);
    #1;
    check("s4_re_c0", fifo_re, 1);
    @(negedge clk); #1;
    check("s4_re_c1", fifo_re, 1);
    for (int c = 2; c < 10; c++) begin
      @(negedge clk); #1;
      check("s4_re_stall",    fifo_re,   0);
      check("s4_valid_stall", add_valid, 1);
      check("s4_index_stall", add_index, 6);
      check("s4_p_stall",     add_p,     mk_p(base));
    end
    @(negedge clk); add_ready = 1'b1; #1;
    check("s4_valid_c10", add_valid, 1);
    check("s4_index_c10", add_index, 6);
    check("s4_re_c10",    fifo_re,   1);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk); retire_valid = 1'b1; retire_index = IW'(5 + i); #1;
      check("s4_valid_drain", add_valid, 1);
      check("s4_index_drain", add_index, PW'(6 + i));
      check("s4_p_drain",     add_p,     mk_p(base + 8'(i)));
    end
    @(negedge clk); retire_index = 4'd11; #1;
    check("s4_valid_done", add_valid, 0);
    @(negedge clk); retire_valid = 1'b0; #1;
    check("s4_busy_end", busy, 0);
    check("s4_count",    PW'(disp_n - d0), 6);

    // ---- S5: reset with buffer full and buckets 1,2,3 dispatched ----
    @(negedge clk);
    base = wr_ptr; push(1); push(2); push(3); push(4); push(5); push(9); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("s5_index_c2", add_index, 1);
    @(negedge clk); #1;
    check("s5_index_c3", add_index, 2);
    @(negedge clk); #1;
    check("s5_index_c4", add_index, 3);
    @(negedge clk); add_ready = 1'b0; #1;
    check("s5_valid_c5", add_valid, 1);
    check("s5_index_c5", add_index, 4);
    check("s5_re_c5",    fifo_re,   0);
    @(negedge clk); #1;
    check("s5_re_full",   fifo_re, 0);
    check("s5_busy_full", busy,    1);
    rst_n = 1'b0; #1;
    check("s5_rst_re",    fifo_re,   0);
    check("s5_rst_valid", add_valid, 0);
    check("s5_rst_index", add_index, 0);
    check("s5_rst_p",     add_p,     0);
    check("s5_rst_busy",  busy,      0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; add_ready = 1'b1; #1;
    check("s5_rel_re",    fifo_re,   1);
    check("s5_rel_valid", add_valid, 0);
    check("s5_rel_busy",  busy,      0);
    @(negedge clk); #1;
    check("s5_r1_valid", add_valid, 0);
    check("s5_r1_busy",  busy,      1);
    @(negedge clk); #1;
    check("s5_r2_valid", add_valid, 1);
    check("s5_r2_index", add_index, 9);
    check("s5_r2_p",     add_p,     mk_p(base + 8'd5));
    @(negedge clk); retire_valid = 1'b1; retire_index = 4'd9; #1;
    check("s5_r3_valid", add_valid, 0);
    @(negedge clk); retire_valid = 1'b0; #1;
    check("s5_busy_end", busy, 0);

    // ---- S6: indices 7,7, plus a retire of an idle bucket ----
    @(negedge clk);
    d0 = disp_n; push(7); push(7); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("s6_valid_c2", add_valid, 1);
    check("s6_index_c2", add_index, 7);
    @(negedge clk); retire_valid = 1'b1; retire_index = 4'd7; #1;
    check("s6_valid_c3", add_valid, !HZ);
    check("s6_index_c3", add_index, 7);
    @(negedge clk); retire_valid = 1'b0; #1;
    check("s6_valid_c4", add_valid, HZ);
    @(negedge clk); retire_valid = 1'b1; retire_index = 4'd7; #1;
    check("s6_valid_c5", add_valid, 0);
    @(negedge clk); retire_index = 4'd12; #1;
    check("s6_busy_idle_retire", busy, 0);
    @(negedge clk); retire_valid = 1'b0; #1;
    check("s6_busy_end", busy, 0);
    check("s6_count",    PW'(disp_n - d0), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
